// File: rtl/zone_bl_pkg.sv
// Shared constants and FSM state type for the zone grey buffer writer/reader pair.
package zone_bl_pkg;

  localparam int GRAY_W          = 16;
  localparam int WORDS_PER_LATCH = 6;
  localparam int LATCH_W         = GRAY_W * WORDS_PER_LATCH;
  localparam int CNTLATCH_W      = 7;
  localparam int NUM_LATCH_DEF   = 64;
  // Number of zones held in the buffer, agreed with the writer side.
  localparam int NUM_ZONES       = NUM_LATCH_DEF * WORDS_PER_LATCH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME,
    ST_READ,
    ST_CAPT,
    ST_PUSH
  } state_e;

endpackage

// File: rtl/zone_latch_packer.sv
// Slot register bank that collects grey values and presents a packed latch word.
// The output word is reloaded only on load, so it holds steady while the next word is read.
module zone_latch_packer
  import zone_bl_pkg::*;
#(
  parameter int GRAY_W          = zone_bl_pkg::GRAY_W,
  parameter int WORDS_PER_LATCH = zone_bl_pkg::WORDS_PER_LATCH,
  parameter int SLOT_W          = (WORDS_PER_LATCH > 1) ? $clog2(WORDS_PER_LATCH) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [SLOT_W-1:0]                 wr_slot,
  input  logic [GRAY_W-1:0]                 wr_data,
  input  logic                              load,
  output logic [GRAY_W*WORDS_PER_LATCH-1:0] datain
);

  logic [WORDS_PER_LATCH-1:0][GRAY_W-1:0] slot_q, slot_d;
  logic [GRAY_W*WORDS_PER_LATCH-1:0]      word_q, word_d;

  // The final slot is written on the same edge as load, so the word takes slot_d.
  always_comb begin
    slot_d = slot_q;
    word_d = word_q;
    if (wr_en) slot_d[wr_slot] = wr_data;
    if (load) word_d = slot_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      word_q <= '0;
    end else begin
      slot_q <= slot_d;
      word_q <= word_d;
    end
  end

  assign datain = word_q;

endmodule

// File: rtl/zone_latch_reader.sv
// Frame-triggered reader: fetches zone grey values in address order, packs them into
// latch words and hands each word downstream with a valid/ready handshake.
module zone_latch_reader
  import zone_bl_pkg::*;
#(
  parameter int NUM_LATCH       = zone_bl_pkg::NUM_LATCH_DEF,
  parameter int GRAY_W          = zone_bl_pkg::GRAY_W,
  parameter int WORDS_PER_LATCH = zone_bl_pkg::WORDS_PER_LATCH,
  parameter int ADDR_W          = 10,
  parameter int BASE_ADDR       = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame_start,
  output logic                              rd_en,
  output logic [ADDR_W-1:0]                 rd_addr,
  input  logic [GRAY_W-1:0]                 rd_data,
  output logic                              frame_flag,
  output logic                              latch_flag,
  input  logic                              latch_ready,
  output logic [GRAY_W*WORDS_PER_LATCH-1:0] datain,
  output logic [CNTLATCH_W-1:0]             cntlatch,
  output logic                              busy,
  output logic                              frame_overrun
);

  localparam int K_W = (WORDS_PER_LATCH > 1) ? $clog2(WORDS_PER_LATCH) : 1;
  localparam logic [CNTLATCH_W-1:0] LAST_IDX = CNTLATCH_W'(NUM_LATCH - 1);
  localparam logic [K_W-1:0]        K_LAST   = K_W'(WORDS_PER_LATCH - 1);

  if (NUM_LATCH < 1 || NUM_LATCH > 128) begin : g_num_latch_chk
    $error("zone_latch_reader: NUM_LATCH must be within 1..128");
  end
  if (BASE_ADDR + NUM_LATCH * WORDS_PER_LATCH > (1 << ADDR_W)) begin : g_addr_chk
    $error("zone_latch_reader: frame does not fit in the ADDR_W address space");
  end

  state_e                state_q, state_d;
  logic [CNTLATCH_W-1:0] idx_q, idx_d;
  logic [K_W-1:0]        k_q, k_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic                  cap_en_q, cap_en_d;
  logic [K_W-1:0]        cap_slot_q, cap_slot_d;
  logic [ADDR_W-1:0]     addr_calc;

  // Handshake: a word transfers on a clock edge where latch_flag and latch_ready are both high;
  // latch_flag, datain and cntlatch stay unchanged until that edge.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    k_d        = k_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    cap_en_d   = 1'b0;
    cap_slot_d = k_q;

    if (frame_start && state_q != ST_IDLE) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start || pending_q) begin
          state_d   = ST_FRAME;
          pending_d = 1'b0;
        end
      end
      ST_FRAME: begin
        idx_d   = '0;
        k_d     = '0;
        state_d = ST_READ;
      end
      ST_READ: begin
        cap_en_d = 1'b1;
        k_d      = k_q + K_W'(1);
        if (k_q == K_LAST) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (latch_ready) begin
          if (idx_q == LAST_IDX) begin
            // A queued frame starts immediately; a start pulse landing now becomes the new queue entry.
            if (pending_q) begin
              state_d   = ST_FRAME;
              pending_d = frame_start;
              overrun_d = overrun_q;
            end else if (frame_start) begin
              state_d   = ST_FRAME;
              pending_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d   = idx_q + CNTLATCH_W'(1);
            k_d     = '0;
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      k_q        <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      cap_en_q   <= 1'b0;
      cap_slot_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      cap_en_q   <= cap_en_d;
      cap_slot_q <= cap_slot_d;
    end
  end

  assign addr_calc = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q) * ADDR_W'(WORDS_PER_LATCH) + ADDR_W'(k_q);

  assign rd_en         = (state_q == ST_READ);
  assign rd_addr       = rd_en ? addr_calc : '0;
  assign frame_flag    = (state_q == ST_FRAME);
  assign latch_flag    = (state_q == ST_PUSH);
  assign busy          = (state_q != ST_IDLE);
  assign cntlatch      = idx_q;
  assign frame_overrun = overrun_q;

  zone_latch_packer #(
    .GRAY_W         (GRAY_W),
    .WORDS_PER_LATCH(WORDS_PER_LATCH),
    .SLOT_W         (K_W)
  ) u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (cap_en_q),
    .wr_slot(cap_slot_q),
    .wr_data(rd_data),
    .load   (state_q == ST_CAPT),
    .datain (datain)
  );

endmodule

// File: tb/tb_zone_latch_reader.sv
// Directed-plus-random bench for zone_latch_reader: a 4-word instance for protocol cases
// and a 128-word instance for full-range addressing.
module tb_zone_latch_reader;
  import zone_bl_pkg::*;

  localparam int NL      = 4;
  localparam int NL_FULL = 128;
  localparam int LW      = LATCH_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            frame_start, rd_en, frame_flag, latch_flag, latch_ready, busy, frame_overrun;
  logic [9:0]      rd_addr;
  logic [15:0]     rd_data;
  logic [LW-1:0]   datain;
  logic [6:0]      cntlatch;

  logic            f_frame_start, f_rd_en, f_frame_flag, f_latch_flag, f_latch_ready, f_busy, f_overrun;
  logic [9:0]      f_rd_addr;
  logic [15:0]     f_rd_data;
  logic [LW-1:0]   f_datain;
  logic [6:0]      f_cntlatch;

  logic [15:0]     mem [0:1023];

  int checks = 0;
  int failures = 0;

  zone_latch_reader #(.NUM_LATCH(NL), .ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_flag(frame_flag), .latch_flag(latch_flag), .latch_ready(latch_ready),
    .datain(datain), .cntlatch(cntlatch), .busy(busy), .frame_overrun(frame_overrun)
  );

  zone_latch_reader #(.NUM_LATCH(NL_FULL), .ADDR_W(10), .BASE_ADDR(0)) dut_full (
    .clk(clk), .rst_n(rst_n), .frame_start(f_frame_start), .rd_en(f_rd_en), .rd_addr(f_rd_addr),
    .rd_data(f_rd_data), .frame_flag(f_frame_flag), .latch_flag(f_latch_flag),
    .latch_ready(f_latch_ready), .datain(f_datain), .cntlatch(f_cntlatch), .busy(f_busy),
    .frame_overrun(f_overrun)
  );

  // zone buffer models: synchronous read, data one cycle after the strobe
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  always @(posedge clk) if (f_rd_en) f_rd_data <= mem[f_rd_addr];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // reference model: word idx is the six buffer values at base+idx*6+j, slot j at bits 16j
  function automatic logic [LW+6:0] model_word(input int idx);
    logic [LW-1:0] w;
    for (int j = 0; j < WORDS_PER_LATCH; j++)
      w[GRAY_W*j +: GRAY_W] = mem[(idx * WORDS_PER_LATCH + j) % 1024];
    return {7'(idx), w};
  endfunction

  // scoreboard
  logic [LW+6:0] exp_q[$];
  logic [LW+6:0] exp_full_q[$];
  logic [LW+6:0] e, ef;
  int frame_cnt = 0;
  int f_acc_cnt = 0;
  int f_rd_seen = 0;
  logic [9:0] f_last_addr = '0;
  logic [6:0] f_last_cnt = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_flag) frame_cnt++;
      if (latch_flag && latch_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $error("FAIL unexpected_word observed=%0h expected=none", cntlatch);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", datain, e[LW-1:0]);
          chk("word_idx", cntlatch, e[LW+6:LW]);
        end
      end
      if (f_rd_en) begin
        chk("full_addr_seq", f_rd_addr, (f_rd_seen != 0) ? f_last_addr + 10'd1 : 10'd0);
        f_last_addr = f_rd_addr;
        f_rd_seen = 1;
      end
      if (f_latch_flag && f_latch_ready) begin
        f_acc_cnt++;
        f_last_cnt = f_cntlatch;
        if (exp_full_q.size() != 0) begin
          ef = exp_full_q.pop_front();
          chk("full_word_data", f_datain, ef[LW-1:0]);
          chk("full_word_idx", f_cntlatch, ef[LW+6:LW]);
        end
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(model_word(i));
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    if (busy) fail(tag);
  endtask

  task automatic wait_read_of(input logic [6:0] idx, input string tag);
    int n = 0;
    while (!(rd_en && cntlatch == idx) && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) fail(tag);
  endtask

  task automatic wait_flag(input string tag);
    int n = 0;
    while (!latch_flag && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) fail(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_frame_flag"}, frame_flag, 0);
    chk({tag, "_latch_flag"}, latch_flag, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, frame_overrun, 0);
    chk({tag, "_datain"}, datain, 0);
    chk({tag, "_cntlatch"}, cntlatch, 0);
  endtask

  logic [LW-1:0] hold;
  logic [LW+6:0] mw;
  int fc0, n, w, ph;
  logic exp_rd, exp_lf;

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; latch_ready = 1'b1;
    f_frame_start = 1'b0; f_latch_ready = 1'b1;
    for (int a = 0; a < 1024; a++) mem[a] = 16'(a);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_full_busy", f_busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // basic frame, mem[a] = a, ready tied high
    push_frame(NL);
    pulse_start();
    for (int cyc = 1; cyc <= 34; cyc++) begin
      @(negedge clk);
      w  = (cyc >= 2) ? (cyc - 2) / 8 : 0;
      ph = (cyc >= 2) ? (cyc - 2) % 8 : 0;
      exp_rd = (cyc >= 2) && (cyc <= 33) && (ph <= 5);
      exp_lf = (cyc >= 2) && (cyc <= 33) && (ph == 7);
      chk("basic_frame_flag", frame_flag, (cyc == 1));
      chk("basic_rd_en", rd_en, exp_rd);
      chk("basic_rd_addr", rd_addr, exp_rd ? (w * 6 + ph) : 0);
      chk("basic_latch_flag", latch_flag, exp_lf);
      chk("basic_busy", busy, (cyc <= 33));
      if (cyc >= 2 && cyc <= 33) chk("basic_cntlatch", cntlatch, w);
      if (cyc == 9)  chk("basic_word0", datain, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0});
      if (cyc == 12) chk("basic_word0_hold", datain, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0});
      if (cyc == 33) chk("basic_word3_slot0", datain[15:0], 16'd18);
    end
    chk("basic_sb_empty", exp_q.size(), 0);

    // backpressure on word 1
    randomize_mem();
    push_frame(NL);
    mw = model_word(1);
    pulse_start();
    wait_read_of(7'd1, "bp_wait_read1");
    latch_ready = 1'b0;
    wait_flag("bp_wait_flag");
    hold = datain;
    chk("bp_word1", hold, mw[LW-1:0]);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_flag_held", latch_flag, 1);
      chk("bp_data_held", datain, hold);
      chk("bp_cnt_held", cntlatch, 1);
      chk("bp_no_rd", rd_en, 0);
    end
    latch_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_flag_drop", latch_flag, 0);
    chk("bp_rd_resume", rd_en, 1);
    chk("bp_rd_addr", rd_addr, 12);
    chk("bp_cnt_next", cntlatch, 2);
    wait_idle(200, "bp_idle");

    // queued frame
    randomize_mem();
    fc0 = frame_cnt;
    push_frame(NL);
    push_frame(NL);
    pulse_start();
    repeat (15) @(posedge clk);
    pulse_start();
    n = 0;
    @(negedge clk);
    while (!(latch_flag && latch_ready && cntlatch == 7'(NL - 1)) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) fail("q_wait_final");
    @(negedge clk);
    chk("q_second_frame_flag", frame_flag, 1);
    chk("q_busy_kept", busy, 1);
    wait_idle(200, "q_idle");
    chk("q_frames", frame_cnt - fc0, 2);
    chk("q_no_overrun", frame_overrun, 0);

    // overrun: three starts within one frame
    randomize_mem();
    fc0 = frame_cnt;
    push_frame(NL);
    push_frame(NL);
    pulse_start();
    repeat (3) @(posedge clk);
    pulse_start();
    chk("ovr_not_yet", frame_overrun, 0);
    repeat (3) @(posedge clk);
    pulse_start();
    chk("ovr_set", frame_overrun, 1);
    wait_idle(300, "ovr_idle");
    repeat (5) @(negedge clk);
    chk("ovr_frames", frame_cnt - fc0, 2);
    chk("ovr_sticky", frame_overrun, 1);

    // random backpressure frame
    randomize_mem();
    push_frame(NL);
    pulse_start();
    n = 0;
    while (busy && n < 600) begin
      latch_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    latch_ready = 1'b1;
    if (busy) fail("rnd_idle");
    chk("rnd_sb_empty", exp_q.size(), 0);
    chk("rnd_overrun_sticky", frame_overrun, 1);

    // reset during word 2 PUSH with a frame queued
    randomize_mem();
    push_frame(NL);
    pulse_start();
    repeat (2) @(posedge clk);
    pulse_start();
    wait_read_of(7'd2, "rst_wait_read2");
    latch_ready = 1'b0;
    wait_flag("rst_wait_flag");
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    chk("rst_words_left", exp_q.size(), 2);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    latch_ready = 1'b1;
    fc0 = frame_cnt;
    repeat (20) begin
      @(posedge clk); #1;
      chk("rst_quiet_busy", busy, 0);
      chk("rst_quiet_rd", rd_en, 0);
    end
    chk("rst_no_frame", frame_cnt - fc0, 0);
    push_frame(NL);
    pulse_start();
    wait_idle(200, "rst_new_idle");
    chk("rst_new_sb_empty", exp_q.size(), 0);
    chk("rst_new_frames", frame_cnt - fc0, 1);

    // full-size addressing on the 128-word instance
    for (int i = 0; i < NL_FULL; i++) exp_full_q.push_back(model_word(i));
    @(posedge clk); #1 f_frame_start = 1'b1;
    @(posedge clk); #1 f_frame_start = 1'b0;
    n = 0;
    while (f_busy && n < 2000) begin @(negedge clk); n++; end
    if (f_busy) fail("full_idle");
    repeat (2) @(negedge clk);
    chk("full_last_addr", f_last_addr, 767);
    chk("full_last_cnt", f_last_cnt, 127);
    chk("full_word_count", f_acc_cnt, NL_FULL);
    chk("full_sb_empty", exp_full_q.size(), 0);
    chk("full_no_overrun", f_overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
